// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch constants and the queue entry type.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side and decode-side handshake of the fetch queue.
interface fetch_queue_if #(parameter int DATA_WIDTH = 32, parameter int DEPTH = 4);
  logic in_valid;
  logic [DATA_WIDTH-1:0] in_instr;
  logic [DATA_WIDTH-1:0] in_pc;
  logic in_ready;
  logic flush;
  logic out_valid;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_pc_plus4;
  logic out_ready;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input in_ready, out_valid, out_instr, out_pc, out_pc_plus4, count
  );
  modport slave (
    input in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pc_plus4, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer between fetch and decode with flush on redirect.
// Define FETCH_QUEUE_BYPASS_EN to pass input straight to output when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  fetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic full, empty, push, pop, byp;
  logic [DATA_WIDTH-1:0] pc;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty & q.in_valid & q.out_ready & ~q.flush;
`else
  assign byp = 1'b0;
`endif
  assign push = q.in_valid & ~full & ~q.flush & ~byp;
  assign pop = ~empty & q.out_ready & ~q.flush;
  assign pc = byp ? q.in_pc : empty ? DATA_WIDTH'(RESET_VECTOR) : DATA_WIDTH'(mem[rd_ptr].pc);
  assign q.in_ready = ~full;
  assign q.out_valid = ~empty | byp;
  assign q.out_instr = byp ? q.in_instr : empty ? DATA_WIDTH'(NOP_INSTR) : DATA_WIDTH'(mem[rd_ptr].instr);
  assign q.out_pc = pc;
  assign q.out_pc_plus4 = pc + DATA_WIDTH'(4);
  assign q.count = count_q;
  always_ff @(posedge clk) begin
    if (!rst || q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{instr: XLEN'(q.in_instr), pc: XLEN'(q.in_pc)};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue sitting directly downstream of the fetch stage (PC register + instruction ROM) and upstream of decode. Buffers up to DEPTH fetched instructions with their PC so a decode stall does not drop fetched words, supplies PC+4 for link-register writeback, and discards all buffered entries on a control-flow redirect. Valid/ready handshake on both sides; back-pressure on the input side is the fetch stage's stall signal.

## Interface

- DATA_WIDTH, 32, instruction/address width
- DEPTH, 4, entry count; power of two, ≥ 2
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  fetch presents a valid instruction
- in_instr  in  DATA_WIDTH  fetched instruction word
- in_pc  in  DATA_WIDTH  address of in_instr
- in_ready  out  1  queue can accept; fetch holds its PC while low
- flush  in  1  redirect (branch/jump taken): discard all entries
- out_valid  out  1  head entry valid for decode
- out_instr  out  DATA_WIDTH  head instruction; NOP_INSTR when out_valid=0
- out_pc  out  DATA_WIDTH  head PC; RESET_VECTOR when out_valid=0
- out_pc_plus4  out  DATA_WIDTH  out_pc + 4, modulo 2^DATA_WIDTH
- out_ready  in  1  decode consumes head this cycle
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation

- Circular buffer: wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap), count register.
- push = in_valid & in_ready & ~flush: write {in_instr, in_pc} at wr_ptr, wr_ptr+1.
- pop = out_valid & out_ready & ~flush: rd_ptr+1.
- count next = count + push − pop; push and pop in same cycle leave count unchanged.
- in_ready = (count != DEPTH), from registered count only; no combinational path from out_ready. Full queue with simultaneous pop still refuses the push that cycle.
- out_valid = (count != 0); out_instr/out_pc read combinationally from entry rd_ptr.
- flush: next cycle count=0, wr_ptr=rd_ptr=0; same-cycle in_valid and out_ready ignored (neither push nor pop occurs). Storage contents not cleared.
- Reset (rst=0 at clock edge): count=0, pointers=0; hence out_valid=0, in_ready=1, out_instr=NOP_INSTR (32'h00000013), out_pc=RESET_VECTOR (32'hBFC00000), out_pc_plus4=32'hBFC00004. Reset overrides flush, push and pop. Reset mid-operation discards all entries identically.
- Instruction order strictly preserved; no entry ever duplicated or dropped except by flush/reset.

## Timing

- Without bypass: entry pushed in cycle N visible at out_* in cycle N+1 (1-cycle latency); throughput one instruction/cycle in steady state.
- in_ready deasserts in the cycle after the push that fills the queue; reasserts in the cycle after the first pop from full.
- After flush in cycle N: out_valid=0 and in_ready=1 in cycle N+1; first post-redirect instruction accepted in N+1.
- count never exceeds DEPTH nor underflows.

## Configuration

- FETCH_QUEUE_BYPASS_EN defined: when count=0, in_valid=1, out_ready=1, flush=0, input drives out_* combinationally (out_valid=1) and is consumed in the same cycle without being written; count stays 0. Zero-cycle latency when empty. When count=0 but out_ready=0, normal push.
- Not defined: no in→out combinational path; behaviour as in Timing.

## Structure

- Shared package fetch_pkg: RESET_VECTOR (32'hBFC00000), NOP_INSTR (32'h00000013), typedef fetch_entry_t packed struct {instr, pc}. PC+4 computed at output, not stored.
- Storage, pointers and count inline; no sub-module.

## Test plan

- Reset: hold rst=0 two cycles with in_valid=1 -> count=0, out_valid=0, out_pc=32'hBFC00000, out_instr=32'h00000013, in_ready=1.
- Fill: out_ready=0, push PCs 0xBFC00000..0xBFC0000C -> count=4, in_ready=0 next cycle; 5th word not accepted; drain returns all four in order, out_pc_plus4=out_pc+4.
- Streaming: in_valid=out_ready=1 for 20 cycles -> count stays 1 (no bypass) / 0 (bypass), every PC emitted once, in order.
- Full + simultaneous pop: count=4, in_valid=out_ready=1 -> that cycle pop only, count=3; next cycle push and pop, count stays 3.
- Flush: count=3, flush=1 with in_valid=out_ready=1 -> next cycle count=0, out_valid=0; flushed and same-cycle input words never appear at output.
- Wrap: push/pop 9 entries across DEPTH=4 boundary with random out_ready -> output sequence equals input sequence.
